// File: rtl/ddram_responder.sv
// ddram_responder
//   Behavioural DDRAM-style memory responder: a 2^ADDR_W x 64-bit store
//   reached through a burst read/write port. Reads return their first beat
//   READ_LAT cycles after the accept edge, then one beat per cycle.
//
// Parameters
//   ADDR_W    log2 of the number of 64-bit words in the store (default 12)
//   READ_LAT  cycles from read accept to first DDRAM_DOUT_READY (1..15)
//
// Ports
//   DDRAM_CLK         in   sole clock, rising edge
//   reset             in   asynchronous, active-high reset
//   DDRAM_BUSY        out  request presented this cycle is not accepted
//   DDRAM_BURSTCNT    in   [7:0]  beats per burst (0 treated as 1)
//   DDRAM_ADDR        in   [28:0] word address, low ADDR_W bits used
//   DDRAM_RD          in   read request
//   DDRAM_DOUT        out  [63:0] read data beat (held between beats)
//   DDRAM_DOUT_READY  out  DDRAM_DOUT valid this cycle
//   DDRAM_DIN         in   [63:0] write data beat
//   DDRAM_BE          in   [7:0]  byte enables, bit n -> DIN[8n+7:8n]
//   DDRAM_WE          in   write beat strobe
//   fsm_state         out  [1:0] current FSM state (debug observation)
//
// Handshake: a request (DDRAM_RD or DDRAM_WE high) is accepted on a rising
// edge of DDRAM_CLK exactly when DDRAM_BUSY is low during that cycle; the
// requester holds it until then. DDRAM_DOUT_READY is a pure strobe with no
// back-pressure.
//
// Build option
//   DDRAM_RESP_BUSY_INJECT_EN  adds a 4-bit LFSR (x^4+x^3+1, seed 4'b1001)
//   that stalls IDLE/WR_BURST requests whenever LFSR[0] is 1.

module ddram_responder #(
    parameter int ADDR_W   = 12,
    parameter int READ_LAT = 4
) (
    input  logic        DDRAM_CLK,
    input  logic        reset,
    output logic        DDRAM_BUSY,
    input  logic [7:0]  DDRAM_BURSTCNT,
    input  logic [28:0] DDRAM_ADDR,
    input  logic        DDRAM_RD,
    output logic [63:0] DDRAM_DOUT,
    output logic        DDRAM_DOUT_READY,
    input  logic [63:0] DDRAM_DIN,
    input  logic [7:0]  DDRAM_BE,
    input  logic        DDRAM_WE,
    output logic [1:0]  fsm_state
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WR_BURST = 2'd1;
    localparam logic [1:0] RD_WAIT  = 2'd2;
    localparam logic [1:0] RD_DATA  = 2'd3;

    logic [63:0]       mem [0:(1<<ADDR_W)-1];

    logic [1:0]        state;
    logic [ADDR_W-1:0] base;
    logic [7:0]        count;
    logic [7:0]        idx;
    logic [3:0]        wait_cnt;
    logic [63:0]       dout;
    logic              dout_ready;

    logic [7:0]        eff_cnt;
    logic              inject_busy;
    logic              busy;
    logic              write_go;
    logic              read_go;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              addr_unused;

    // Address bits above the store size are intentionally ignored.
    assign addr_unused = ^DDRAM_ADDR[28:ADDR_W];

`ifdef DDRAM_RESP_BUSY_INJECT_EN
    logic [3:0] lfsr;

    always_ff @(posedge DDRAM_CLK or posedge reset) begin
        if (reset) begin
            lfsr <= 4'b1001;
        end else begin
            lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        end
    end

    assign inject_busy = lfsr[0] && ((state == IDLE) || (state == WR_BURST));
`else
    assign inject_busy = 1'b0;
`endif

    assign eff_cnt  = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;
    assign busy     = (state == RD_WAIT) || (state == RD_DATA) || inject_busy;
    // WE wins over RD in IDLE; RD is ignored entirely while a write burst runs.
    assign write_go = DDRAM_WE && !busy && !reset &&
                      ((state == IDLE) || (state == WR_BURST));
    assign read_go  = DDRAM_RD && !DDRAM_WE && !busy && (state == IDLE);
    // Burst addresses wrap naturally at the store boundary (ADDR_W-bit add).
    assign wr_addr  = (state == IDLE) ? DDRAM_ADDR[ADDR_W-1:0]
                                      : base + ADDR_W'(idx);
    assign rd_addr  = base + ADDR_W'(idx);

    assign DDRAM_BUSY       = busy;
    assign DDRAM_DOUT       = dout;
    assign DDRAM_DOUT_READY = dout_ready;
    assign fsm_state        = state;

    // Store has no reset: contents survive a reset.
    always_ff @(posedge DDRAM_CLK) begin
        if (write_go) begin
            for (int b = 0; b < 8; b++) begin
                if (DDRAM_BE[b]) begin
                    mem[wr_addr][8*b +: 8] <= DDRAM_DIN[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge DDRAM_CLK or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            base       <= '0;
            count      <= 8'd0;
            idx        <= 8'd0;
            wait_cnt   <= 4'd0;
            dout       <= 64'd0;
            dout_ready <= 1'b0;
        end else begin
            dout_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (write_go) begin
                        base  <= DDRAM_ADDR[ADDR_W-1:0];
                        count <= eff_cnt;
                        idx   <= 8'd1;
                        if (eff_cnt > 8'd1) begin
                            state <= WR_BURST;
                        end
                    end else if (read_go) begin
                        base     <= DDRAM_ADDR[ADDR_W-1:0];
                        count    <= eff_cnt;
                        idx      <= 8'd0;
                        wait_cnt <= 4'(READ_LAT - 1);
                        state    <= RD_WAIT;
                    end
                end
                WR_BURST: begin
                    if (write_go) begin
                        idx <= idx + 8'd1;
                        if (idx == count - 8'd1) begin
                            state <= IDLE;
                        end
                    end
                end
                RD_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        dout       <= mem[rd_addr];
                        dout_ready <= 1'b1;
                        idx        <= idx + 8'd1;
                        state      <= RD_DATA;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RD_DATA: begin
                    // The last beat is presented while still in RD_DATA so
                    // BUSY covers every beat of the burst.
                    if (idx == count) begin
                        state <= IDLE;
                    end else begin
                        dout       <= mem[rd_addr];
                        dout_ready <= 1'b1;
                        idx        <= idx + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddram_responder.sv
// Self-checking bench for ddram_responder: directed write/read bursts, a
// reference store with a queue of scheduled read beats, and a per-cycle
// compare on the falling clock edge.

module tb_ddram_responder;

    localparam int ADDR_W   = 12;
    localparam int READ_LAT = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic        clk;
    logic        reset;
    logic        busy;
    logic [7:0]  burstcnt;
    logic [28:0] addr;
    logic        rd;
    logic [63:0] dout;
    logic        dout_ready;
    logic [63:0] din;
    logic [7:0]  be;
    logic        we;
    logic [1:0]  fsm_state;

    ddram_responder #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
        .DDRAM_CLK       (clk),
        .reset           (reset),
        .DDRAM_BUSY      (busy),
        .DDRAM_BURSTCNT  (burstcnt),
        .DDRAM_ADDR      (addr),
        .DDRAM_RD        (rd),
        .DDRAM_DOUT      (dout),
        .DDRAM_DOUT_READY(dout_ready),
        .DDRAM_DIN       (din),
        .DDRAM_BE        (be),
        .DDRAM_WE        (we),
        .fsm_state       (fsm_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model / scoreboard ----------------
    logic [63:0] ref_mem [0:DEPTH-1];
    logic [63:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [63:0] got_q[$];
    logic [63:0] wdata [0:15];
    logic [63:0] last_dout;
    int          ncyc;
    int          win_lo;
    int          win_hi;
    int          checks;
    int          errors;

    initial begin
        ncyc      = 0;
        win_lo    = 1;
        win_hi    = 0;
        checks    = 0;
        errors    = 0;
        last_dout = 64'd0;
    end

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_write(input logic [ADDR_W-1:0] a, input logic [63:0] d, input logic [7:0] m);
        for (int b = 0; b < 8; b++) begin
            if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_cyc_q.delete();
        win_lo    = 1;
        win_hi    = 0;
        last_dout = 64'd0;
    endtask

    // Compare process: every falling edge, outputs against the model.
    always @(negedge clk) begin
        logic exp_rdy;
        logic in_win;
        if (reset) begin
            check64("reset_ready", {63'd0, dout_ready}, 64'd0);
            check64("reset_dout", dout, 64'd0);
            check64("reset_busy", {63'd0, busy}, 64'd0);
        end else begin
            exp_rdy = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == ncyc);
            check64("dout_ready", {63'd0, dout_ready}, {63'd0, exp_rdy});
            if (exp_rdy) begin
                check64("dout_beat", dout, exp_q[0]);
                last_dout = exp_q[0];
                got_q.push_back(dout);
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end else begin
                check64("dout_hold", dout, last_dout);
            end
            in_win = (ncyc >= win_lo) && (ncyc <= win_hi);
`ifdef DDRAM_RESP_BUSY_INJECT_EN
            if (in_win) check64("busy_read", {63'd0, busy}, 64'd1);
`else
            check64("busy", {63'd0, busy}, {63'd0, in_win});
`endif
        end
        ncyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic do_write(input logic [28:0] a, input int n, input logic [7:0] cnt_field,
                            input logic [7:0] m, input logic with_rd, output int cycles);
        int k;
        k = 0;
        cycles = 0;
        @(posedge clk); #1;
        while (k < n && cycles < 300) begin
            we       = 1'b1;
            rd       = with_rd;
            addr     = a;
            burstcnt = cnt_field;
            din      = wdata[k];
            be       = m;
            if (!busy) begin
                model_write(a[ADDR_W-1:0] + ADDR_W'(k), wdata[k], m);
                k++;
            end
            cycles++;
            @(posedge clk); #1;
        end
        we = 1'b0;
        rd = 1'b0;
        check64("write_done", 64'(k), 64'(n));
    endtask

    task automatic start_read(input logic [28:0] a, input int n, input logic [7:0] cnt_field,
                              output int acc);
        int t;
        t = 0;
        @(posedge clk); #1;
        while (busy && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        rd       = 1'b1;
        we       = 1'b0;
        addr     = a;
        burstcnt = cnt_field;
        acc      = ncyc;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(ref_mem[a[ADDR_W-1:0] + ADDR_W'(i)]);
            exp_cyc_q.push_back(acc + READ_LAT + 1 + i);
        end
        win_lo = acc + 1;
        win_hi = acc + READ_LAT + n;
        @(posedge clk); #1;
        rd = 1'b0;
    endtask

    task automatic do_read(input logic [28:0] a, input int n, input logic [7:0] cnt_field);
        int acc;
        int t;
        got_q.delete();
        start_read(a, n, cnt_field, acc);
        t = 0;
        while (exp_q.size() > 0 && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        check64("read_done", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int acc;
        int t;
        reset    = 1'b1;
        we       = 1'b0;
        rd       = 1'b0;
        addr     = 29'd0;
        burstcnt = 8'd0;
        din      = 64'd0;
        be       = 8'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check64("state_after_reset", {62'd0, fsm_state}, 64'd0);

        // single write then single read
        wdata[0] = 64'h1122334455667788;
        do_write(29'h10, 1, 8'd1, 8'hFF, 1'b0, cyc);
        do_read(29'h10, 1, 8'd1);
        check64("t1_beats", 64'(got_q.size()), 64'd1);
        check64("t1_data", got_q[0], 64'h1122334455667788);

        // BURSTCNT=0 behaves as one beat; upper address bits ignored
        do_read(29'h1000_0010, 1, 8'd0);
        check64("cnt0_beats", 64'(got_q.size()), 64'd1);
        check64("cnt0_data", got_q[0], 64'h1122334455667788);

        // BE=00 leaves the word unchanged
        wdata[0] = 64'd0;
        do_write(29'h10, 1, 8'd1, 8'h00, 1'b0, cyc);
        do_read(29'h10, 1, 8'd1);
        check64("be0_data", got_q[0], 64'h1122334455667788);

        // partial byte enables
        wdata[0] = '1;
        do_write(29'h20, 1, 8'd1, 8'hFF, 1'b0, cyc);
        wdata[0] = 64'd0;
        do_write(29'h20, 1, 8'd1, 8'h0C, 1'b0, cyc);
        do_read(29'h20, 1, 8'd1);
        check64("be0c_data", got_q[0], 64'hFFFFFFFF0000FFFF);

        // wrapping write burst across the store boundary
        wdata[0] = 64'hA2A2A2A2A2A2A2A2;
        wdata[1] = 64'hA3A3A3A3A3A3A3A3;
        do_write(29'h2, 2, 8'd2, 8'hFF, 1'b0, cyc);
        for (int i = 0; i < 4; i++) wdata[i] = 64'(i + 1);
        do_write(29'(DEPTH - 2), 4, 8'd4, 8'hFF, 1'b0, cyc);
        do_read(29'h0, 4, 8'd4);
        check64("wrap_b0", got_q[0], 64'd3);
        check64("wrap_b1", got_q[1], 64'd4);
        check64("wrap_b2", got_q[2], 64'hA2A2A2A2A2A2A2A2);
        check64("wrap_b3", got_q[3], 64'hA3A3A3A3A3A3A3A3);
        do_read(29'(DEPTH - 2), 4, 8'd4);
        check64("wrap_rd_b0", got_q[0], 64'd1);
        check64("wrap_rd_b3", got_q[3], 64'd4);

        // read burst 8
        for (int i = 0; i < 8; i++) wdata[i] = 64'h100 + 64'(i);
        do_write(29'h40, 8, 8'd8, 8'hFF, 1'b0, cyc);
        do_read(29'h40, 8, 8'd8);
        check64("b8_beats", 64'(got_q.size()), 64'd8);
        check64("b8_last", got_q[7], 64'h107);

        // RD+WE together in IDLE, and RD held through a write burst
        got_q.delete();
        wdata[0] = 64'hDEADBEEFCAFEF00D;
        wdata[1] = 64'h0123456789ABCDEF;
        do_write(29'h50, 2, 8'd2, 8'hFF, 1'b1, cyc);
        repeat (READ_LAT + 4) @(posedge clk);
        #1;
        check64("rdwe_no_beats", 64'(got_q.size()), 64'd0);
        do_read(29'h50, 2, 8'd2);
        check64("rdwe_w0", got_q[0], 64'hDEADBEEFCAFEF00D);
        check64("rdwe_w1", got_q[1], 64'h0123456789ABCDEF);

        // reset during beat 2 of a burst-8 read
        got_q.delete();
        start_read(29'h40, 8, 8'd8, acc);
        t = 0;
        while (ncyc != acc + READ_LAT + 3 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check64("beat2_reached", 64'(ncyc), 64'(acc + READ_LAT + 3));
        reset = 1'b1;
        model_reset();
        #1;
        check64("rst_ready_now", {63'd0, dout_ready}, 64'd0);
        check64("rst_busy_now", {63'd0, busy}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (READ_LAT + 10) @(posedge clk);
        #1;
        check64("rst_beats_seen", 64'(got_q.size()), 64'd2);
        do_read(29'h40, 8, 8'd8);
        check64("rst_reread_b0", got_q[0], 64'h100);
        check64("rst_reread_b7", got_q[7], 64'h107);

        // write burst 16 held on WE
        for (int i = 0; i < 16; i++) wdata[i] = 64'h200 + 64'(i);
        do_write(29'h80, 16, 8'd16, 8'hFF, 1'b0, cyc);
`ifndef DDRAM_RESP_BUSY_INJECT_EN
        check64("b16_cycles", 64'(cyc), 64'd16);
`endif
        do_read(29'h80, 16, 8'd16);
        check64("b16_beats", 64'(got_q.size()), 64'd16);
        check64("b16_last", got_q[15], 64'h20F);

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddram_responder.md
DDRAM_RESPONDER -- requirements
Module: ddram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning log2 of the number of 64-bit words in the backing store.
REQ-002 SHALL have parameter READ_LAT, default 4, range 1..15, meaning cycles from read accept to the first DDRAM_DOUT_READY.
REQ-003 SHALL have port DDRAM_CLK  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port DDRAM_BUSY  out  1  high means the request presented this cycle is not accepted.
REQ-006 SHALL have port DDRAM_BURSTCNT  in  8  beats in the burst; 0 treated as 1.
REQ-007 SHALL have port DDRAM_ADDR  in  29  64-bit word address; only bits [ADDR_W-1:0] used.
REQ-008 SHALL have port DDRAM_RD  in  1  read request.
REQ-009 SHALL have port DDRAM_DOUT  out  64  read data beat.
REQ-010 SHALL have port DDRAM_DOUT_READY  out  1  DDRAM_DOUT valid this cycle.
REQ-011 SHALL have port DDRAM_DIN  in  64  write data beat.
REQ-012 SHALL have port DDRAM_BE  in  8  write byte enables; bit n covers DIN[8n+7:8n].
REQ-013 SHALL have port DDRAM_WE  in  1  write beat strobe.

Function
REQ-014 SHALL implement states IDLE, WR_BURST, RD_WAIT, RD_DATA.
REQ-015 SHALL accept a request only in a cycle where DDRAM_BUSY is low.
REQ-016 In IDLE, accepted DDRAM_WE SHALL write beat 0 at ADDR, latch ADDR and BURSTCNT, and go to WR_BURST if count>1, else stay in IDLE.
REQ-017 In WR_BURST, each accepted DDRAM_WE SHALL write the next beat at base+index; DDRAM_ADDR/BURSTCNT ignored; after the last beat return to IDLE.
REQ-018 Writes SHALL update only bytes whose DDRAM_BE bit is 1; BE=8'h00 leaves the word unchanged.
REQ-019 In IDLE, accepted DDRAM_RD (WE low) SHALL latch ADDR and BURSTCNT, go to RD_WAIT, and drive DDRAM_BUSY high from the next cycle until returning to IDLE.
REQ-020 The first DDRAM_DOUT_READY SHALL occur exactly READ_LAT cycles after the accept edge, followed by count-1 further beats on consecutive cycles (RD_DATA), then IDLE.
REQ-021 Beat i SHALL return the word at (base+i) mod 2^ADDR_W; burst addressing wraps at the store boundary.
REQ-022 DDRAM_DOUT SHALL hold its last beat value while DDRAM_DOUT_READY is low.
REQ-023 DDRAM_RD and DDRAM_WE high together in IDLE: the write SHALL be performed and the read ignored (no read beats).
REQ-024 DDRAM_RD high during WR_BURST SHALL be ignored; the pending write burst completes first.
REQ-025 A read following a write to the same word SHALL return the written data (no stale read).

Reset
REQ-026 Reset SHALL force state IDLE, DDRAM_BUSY=0, DDRAM_DOUT_READY=0, DDRAM_DOUT=0, beat counters 0, within the same cycle and independent of DDRAM_CLK.
REQ-027 Reset mid-burst SHALL abandon the burst with no further beats; backing-store contents SHALL NOT be cleared.

Configuration
REQ-028 With DDRAM_RESP_BUSY_INJECT_EN defined, a 4-bit LFSR (x^4+x^3+1, reset seed 4'b1001, stepping every cycle) SHALL additionally force DDRAM_BUSY high in IDLE and WR_BURST whenever LFSR[0]=1.
REQ-029 Without DDRAM_RESP_BUSY_INJECT_EN, no LFSR SHALL exist and DDRAM_BUSY SHALL be high only in RD_WAIT and RD_DATA.

Verification
REQ-030 Write ADDR=0x10, BURSTCNT=1, DIN=64'h1122334455667788, BE=FF; then read ADDR=0x10, BURSTCNT=1 -> one beat 64'h1122334455667788, DOUT_READY exactly READ_LAT cycles after accept.
REQ-031 Write 0x20 all-ones, then write 0x20 DIN=0, BE=8'h0C; read -> 64'hFFFFFFFF0000FFFF.
REQ-032 Write burst 4 at ADDR=2^ADDR_W-2 with data 1,2,3,4; read burst 4 at ADDR=0 -> 3,4, then prior contents of words 2,3.
REQ-033 Read burst 8 -> DOUT_READY high 8 consecutive cycles, BUSY high throughout; RD+WE together in IDLE -> write lands, zero read beats.
REQ-034 Assert reset during beat 2 of a read burst 8 -> DOUT_READY and BUSY low immediately, no further beats; re-read returns original data.
REQ-035 With DDRAM_RESP_BUSY_INJECT_EN, write burst 16 held on WE -> all 16 words written despite BUSY stalls; without it, burst completes in 16 cycles.
